// File: rtl/fir_mac_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_mac_scheduler_if : handshake, RAM-address and MAC-strobe bundle        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fir_mac_scheduler_if #(
   parameter int FIR_DEPTH     = 256,
   parameter int NUM_PIPELINES = 8
);
   localparam int ITERS      = FIR_DEPTH / NUM_PIPELINES;
   localparam int ADDR_WIDTH = (FIR_DEPTH > 1) ? $clog2(FIR_DEPTH) : 1;
   localparam int ITER_WIDTH = (ITERS > 1) ? $clog2(ITERS) : 1;

   logic                  i_en;
   logic                  i_sample_valid;
   logic                  o_sample_ready;
   logic                  o_wr_en;
   logic [ADDR_WIDTH-1:0] o_wr_addr;
   logic [ADDR_WIDTH-1:0] o_rd_base;
   logic [ITER_WIDTH-1:0] o_tap_idx;
   logic                  o_acc_en;
   logic                  o_acc_clr;
   logic                  o_reduce_start;
   logic                  i_reduce_done;
   logic                  o_dout_valid;
   logic                  i_dout_ready;
   logic                  o_busy;
   logic                  o_overrun;

   modport master (
      input  i_en, i_sample_valid, i_reduce_done, i_dout_ready,
      output o_sample_ready, o_wr_en, o_wr_addr, o_rd_base, o_tap_idx,
             o_acc_en, o_acc_clr, o_reduce_start, o_dout_valid, o_busy, o_overrun
   );

   modport slave (
      output i_en, i_sample_valid, i_reduce_done, i_dout_ready,
      input  o_sample_ready, o_wr_en, o_wr_addr, o_rd_base, o_tap_idx,
             o_acc_en, o_acc_clr, o_reduce_start, o_dout_valid, o_busy, o_overrun
   );
endinterface
`default_nettype wire

// File: rtl/fir_mac_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_mac_scheduler : per-sample control FSM for the multi-lane FIR MAC path |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fir_mac_scheduler #(
   parameter int DATA_WIDTH    = 24,
   parameter int FIR_DEPTH     = 256,
   parameter int NUM_PIPELINES = 8,
   parameter int MAC_LATENCY   = 3
) (
   input wire logic            i_clk,
   input wire logic            i_rst,
   fir_mac_scheduler_if.master bus
);
   localparam int ITERS       = FIR_DEPTH / NUM_PIPELINES;
   localparam int ADDR_WIDTH  = (FIR_DEPTH > 1) ? $clog2(FIR_DEPTH) : 1;
   localparam int ITER_WIDTH  = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam int DRAIN_WIDTH = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

   localparam logic [ITER_WIDTH-1:0]  C_LAST_ITER  = ITER_WIDTH'(ITERS - 1);
   localparam logic [DRAIN_WIDTH-1:0] C_LAST_DRAIN = DRAIN_WIDTH'(MAC_LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0]  C_LANE_STEP  = ADDR_WIDTH'(NUM_PIPELINES);

   if (((FIR_DEPTH & (FIR_DEPTH - 1)) != 0) || ((FIR_DEPTH % NUM_PIPELINES) != 0) ||
       (MAC_LATENCY < 1) || (DATA_WIDTH < 1)) begin : g_param_check
      $error("fir_mac_scheduler: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WRITE  = 3'd1,
      S_MAC    = 3'd2,
      S_DRAIN  = 3'd3,
      S_REDUCE = 3'd4,
      S_OUTPUT = 3'd5
   } state_t;

   state_t                 state_q;
   logic [ADDR_WIDTH-1:0]  wr_ptr_q;
   logic [ADDR_WIDTH-1:0]  rd_base_q;
   logic [ITER_WIDTH-1:0]  k_q;
   logic [DRAIN_WIDTH-1:0] drain_q;
   logic                   overrun_q;
   logic                   ready_q;
   logic                   wr_en_q;
   logic                   acc_en_q;
   logic                   acc_clr_q;
   logic                   rstart_q;
   logic                   dvalid_q;
   logic                   busy_q;

   // Outputs are registered alongside the state; i_en low holds everything in place.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         rd_base_q <= '0;
         k_q       <= '0;
         drain_q   <= '0;
         overrun_q <= 1'b0;
         ready_q   <= 1'b1;
         wr_en_q   <= 1'b0;
         acc_en_q  <= 1'b0;
         acc_clr_q <= 1'b0;
         rstart_q  <= 1'b0;
         dvalid_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else if (bus.i_en) begin
         if (bus.i_sample_valid && (state_q != S_IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (bus.i_sample_valid) begin
                  state_q <= S_WRITE;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  wr_en_q <= 1'b1;
               end
            end
            S_WRITE: begin
               state_q   <= S_MAC;
               wr_en_q   <= 1'b0;
               k_q       <= '0;
               rd_base_q <= wr_ptr_q;
               acc_en_q  <= 1'b1;
               acc_clr_q <= 1'b1;
            end
            S_MAC: begin
               acc_clr_q <= 1'b0;
               if (k_q == C_LAST_ITER) begin
                  state_q  <= S_DRAIN;
                  acc_en_q <= 1'b0;
                  drain_q  <= '0;
               end else begin
                  k_q       <= k_q + 1'b1;
                  rd_base_q <= rd_base_q - C_LANE_STEP;
               end
            end
            S_DRAIN: begin
               if (drain_q == C_LAST_DRAIN) begin
                  state_q  <= S_REDUCE;
                  drain_q  <= '0;
                  rstart_q <= 1'b1;
               end else begin
                  drain_q <= drain_q + 1'b1;
               end
            end
            S_REDUCE: begin
               rstart_q <= 1'b0;
               if (bus.i_reduce_done) begin
                  state_q  <= S_OUTPUT;
                  dvalid_q <= 1'b1;
               end
            end
            S_OUTPUT: begin
               if (bus.i_dout_ready) begin
                  state_q  <= S_IDLE;
                  dvalid_q <= 1'b0;
                  ready_q  <= 1'b1;
                  busy_q   <= 1'b0;
                  wr_ptr_q <= wr_ptr_q + 1'b1;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               wr_en_q  <= 1'b0;
               acc_en_q <= 1'b0;
               acc_clr_q <= 1'b0;
               rstart_q <= 1'b0;
               dvalid_q <= 1'b0;
               ready_q  <= 1'b1;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   // Strobes are qualified by i_en so a frozen cycle never double-counts an operation.
   assign bus.o_sample_ready = ready_q;
   assign bus.o_wr_en        = wr_en_q & bus.i_en;
   assign bus.o_wr_addr      = wr_ptr_q;
   assign bus.o_rd_base      = rd_base_q;
   assign bus.o_tap_idx      = k_q;
   assign bus.o_acc_en       = acc_en_q & bus.i_en;
   assign bus.o_acc_clr      = acc_clr_q & bus.i_en;
   assign bus.o_reduce_start = rstart_q & bus.i_en;
   assign bus.o_dout_valid   = dvalid_q;
   assign bus.o_busy         = busy_q;
   assign bus.o_overrun      = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_fir_mac_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fir_mac_scheduler : scoreboard bench for the FIR MAC scheduler          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fir_mac_scheduler;
   localparam int FIR_DEPTH = 256;
   localparam int NP        = 8;
   localparam int ML        = 3;
   localparam int ITERS     = FIR_DEPTH / NP;

   typedef struct packed {
      int         cyc;
      logic [7:0] addr;
      logic [4:0] tap;
      logic       clr;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   mon_en = 1'b0;
   logic dv_prev = 1'b0;
   ev_t  em;
   ev_t  q_wr[$];
   ev_t  q_acc[$];
   ev_t  q_rs[$];
   ev_t  q_dv[$];

   fir_mac_scheduler_if #(.FIR_DEPTH(FIR_DEPTH), .NUM_PIPELINES(NP)) bus ();

   fir_mac_scheduler #(
      .DATA_WIDTH(24), .FIR_DEPTH(FIR_DEPTH), .NUM_PIPELINES(NP), .MAC_LATENCY(ML)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time expired, cyc %0d", cyc);
      $fatal(1);
   end

   // Scoreboard monitor: every strobe must match the next expected event.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.o_wr_en === 1'b1) begin
            vectors++;
            if (q_wr.size() == 0) begin
               miscompares++;
               $display("FAIL wr_en: unexpected at cyc %0d addr %0d, required none", cyc, bus.o_wr_addr);
            end else begin
               em = q_wr.pop_front();
               if (em.cyc !== cyc || em.addr !== bus.o_wr_addr) begin
                  miscompares++;
                  $display("FAIL wr_en: got cyc %0d addr %0d, required cyc %0d addr %0d",
                           cyc, bus.o_wr_addr, em.cyc, em.addr);
               end
            end
         end
         if (bus.o_acc_en === 1'b1) begin
            vectors++;
            if (q_acc.size() == 0) begin
               miscompares++;
               $display("FAIL acc_en: unexpected at cyc %0d tap %0d, required none", cyc, bus.o_tap_idx);
            end else begin
               em = q_acc.pop_front();
               if (em.cyc !== cyc || em.addr !== bus.o_rd_base || em.tap !== bus.o_tap_idx ||
                   em.clr !== bus.o_acc_clr) begin
                  miscompares++;
                  $display("FAIL acc_en: got cyc %0d base %0d tap %0d clr %0b, required cyc %0d base %0d tap %0d clr %0b",
                           cyc, bus.o_rd_base, bus.o_tap_idx, bus.o_acc_clr, em.cyc, em.addr, em.tap, em.clr);
               end
            end
         end else if (bus.o_acc_clr !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL acc_clr: got %0b without acc_en at cyc %0d, required 0", bus.o_acc_clr, cyc);
         end
         if (bus.o_reduce_start === 1'b1) begin
            vectors++;
            if (q_rs.size() == 0) begin
               miscompares++;
               $display("FAIL reduce_start: unexpected at cyc %0d, required none", cyc);
            end else begin
               em = q_rs.pop_front();
               if (em.cyc !== cyc) begin
                  miscompares++;
                  $display("FAIL reduce_start: got cyc %0d, required cyc %0d", cyc, em.cyc);
               end
            end
         end
         if (bus.o_dout_valid === 1'b1 && dv_prev !== 1'b1) begin
            vectors++;
            if (q_dv.size() == 0) begin
               miscompares++;
               $display("FAIL dout_valid: unexpected rise at cyc %0d, required none", cyc);
            end else begin
               em = q_dv.pop_front();
               if (em.cyc !== cyc) begin
                  miscompares++;
                  $display("FAIL dout_valid: rose at cyc %0d, required cyc %0d", cyc, em.cyc);
               end
            end
         end
      end
      dv_prev = bus.o_dout_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_sample(input int base, input logic [7:0] addr, input int stall_k,
                              input int stall_len, input int n_acc);
      ev_t e;
      e.cyc = base + 1; e.addr = addr; e.tap = '0; e.clr = 1'b0;
      q_wr.push_back(e);
      for (int k = 0; k < n_acc; k++) begin
         e.cyc  = base + 2 + k + ((k >= stall_k) ? stall_len : 0);
         e.addr = addr - 8'(k * NP);
         e.tap  = 5'(k);
         e.clr  = (k == 0);
         q_acc.push_back(e);
      end
      if (n_acc == ITERS) begin
         e.cyc = base + 2 + ITERS + ML + stall_len;
         q_rs.push_back(e);
      end
   endtask

   // Runs one complete sample with i_dout_ready high; i_en optionally dropped at tap stall_k.
   task automatic do_sample(input logic [7:0] addr, input int done_rel, input int stall_k,
                            input int stall_len);
      int  base;
      ev_t e;
      base = cyc;
      bus.i_sample_valid = 1'b1;
      push_sample(base, addr, stall_k, stall_len, ITERS);
      e = '0;
      e.cyc = base + done_rel + stall_len + 1;
      q_dv.push_back(e);
      for (int c = 1; c <= done_rel + stall_len + 1; c++) begin
         tick();
         bus.i_sample_valid = 1'b0;
         bus.i_en = !(stall_len > 0 && c >= stall_k + 2 && c < stall_k + 2 + stall_len);
         bus.i_reduce_done = (c == done_rel + stall_len);
         #1;
         if (!bus.i_en) begin
            vectors++;
            if (bus.o_tap_idx !== 5'(stall_k) || bus.o_acc_en !== 1'b0) begin
               miscompares++;
               $display("FAIL stall: cyc %0d got tap %0d acc_en %0b, required tap %0d acc_en 0",
                        c, bus.o_tap_idx, bus.o_acc_en, stall_k);
            end
         end
      end
      bus.i_reduce_done = 1'b0;
      tick();
      vectors++;
      if (bus.o_sample_ready !== 1'b1 || bus.o_dout_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL post_handshake: got ready %0b valid %0b busy %0b, required 1 0 0",
                  bus.o_sample_ready, bus.o_dout_valid, bus.o_busy);
      end
   endtask

   task automatic test_reset();
      bus.i_en = 1'b1; bus.i_sample_valid = 1'b0; bus.i_reduce_done = 1'b0; bus.i_dout_ready = 1'b1;
      rst = 1'b1;
      repeat (3) tick();
      vectors++;
      if ({bus.o_sample_ready, bus.o_wr_en, bus.o_acc_en, bus.o_acc_clr, bus.o_reduce_start,
           bus.o_dout_valid, bus.o_busy, bus.o_overrun} !== 8'b1000_0000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b, required 10000000",
                  {bus.o_sample_ready, bus.o_wr_en, bus.o_acc_en, bus.o_acc_clr, bus.o_reduce_start,
                   bus.o_dout_valid, bus.o_busy, bus.o_overrun});
      end
      vectors++;
      if (bus.o_wr_addr !== 8'd0 || bus.o_rd_base !== 8'd0 || bus.o_tap_idx !== 5'd0) begin
         miscompares++;
         $display("FAIL reset_addr: got wr %0d base %0d tap %0d, required 0 0 0",
                  bus.o_wr_addr, bus.o_rd_base, bus.o_tap_idx);
      end
      rst = 1'b0;
      mon_en = 1'b1;
      tick();
   endtask

   task automatic test_single();
      do_sample(8'd0, 40, 99, 0);
      vectors++;
      if (q_wr.size() + q_acc.size() + q_rs.size() + q_dv.size() != 0) begin
         miscompares++;
         $display("FAIL single_drain: %0d events outstanding, required 0",
                  q_wr.size() + q_acc.size() + q_rs.size() + q_dv.size());
      end
   endtask

   task automatic test_backpressure();
      int  base;
      ev_t e;
      bus.i_dout_ready = 1'b0;
      base = cyc;
      bus.i_sample_valid = 1'b1;
      push_sample(base, 8'd1, 99, 0, ITERS);
      e = '0;
      e.cyc = base + 41;
      q_dv.push_back(e);
      for (int c = 1; c <= 142; c++) begin
         tick();
         bus.i_sample_valid = (c == 60);
         bus.i_reduce_done  = (c == 40);
         bus.i_dout_ready   = (c >= 141);
         #1;
         if (c >= 41 && c <= 141) begin
            vectors++;
            if (bus.o_dout_valid !== 1'b1) begin
               miscompares++;
               $display("FAIL hold_valid: cyc %0d got %0b, required 1", c, bus.o_dout_valid);
            end
         end
         if (c == 61 || c == 141) begin
            vectors++;
            if (bus.o_overrun !== 1'b1 || bus.o_wr_addr !== 8'd1) begin
               miscompares++;
               $display("FAIL overrun: cyc %0d got ovr %0b wr_addr %0d, required 1 1",
                        c, bus.o_overrun, bus.o_wr_addr);
            end
         end
      end
      bus.i_dout_ready = 1'b1;
      vectors++;
      if (bus.o_sample_ready !== 1'b1 || bus.o_wr_addr !== 8'd2 || bus.o_dout_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_release: got ready %0b wr_addr %0d valid %0b, required 1 2 0",
                  bus.o_sample_ready, bus.o_wr_addr, bus.o_dout_valid);
      end
   endtask

   task automatic test_back_to_back();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (bus.o_overrun !== 1'b0 || bus.o_wr_addr !== 8'd0) begin
         miscompares++;
         $display("FAIL rst_clear: got ovr %0b wr_addr %0d, required 0 0", bus.o_overrun, bus.o_wr_addr);
      end
      for (int i = 0; i < 257; i++) begin
         do_sample(8'(i), 37, 99, 0);
      end
      vectors++;
      if (bus.o_wr_addr !== 8'd1 || q_acc.size() != 0 || q_dv.size() != 0) begin
         miscompares++;
         $display("FAIL stream: got wr_addr %0d outstanding %0d, required 1 0",
                  bus.o_wr_addr, q_acc.size() + q_dv.size());
      end
   endtask

   task automatic test_enable_stall();
      do_sample(8'd1, 37, 10, 5);
      vectors++;
      if (q_wr.size() + q_acc.size() + q_rs.size() + q_dv.size() != 0) begin
         miscompares++;
         $display("FAIL stall_drain: %0d events outstanding, required 0",
                  q_wr.size() + q_acc.size() + q_rs.size() + q_dv.size());
      end
   endtask

   task automatic test_mid_reset();
      int base;
      base = cyc;
      bus.i_sample_valid = 1'b1;
      push_sample(base, 8'd2, 99, 0, 16);
      for (int c = 1; c <= 17; c++) begin
         tick();
         bus.i_sample_valid = 1'b0;
      end
      vectors++;
      if (bus.o_tap_idx !== 5'd15) begin
         miscompares++;
         $display("FAIL mid_tap: got %0d, required 15", bus.o_tap_idx);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if ({bus.o_sample_ready, bus.o_wr_en, bus.o_acc_en, bus.o_reduce_start, bus.o_dout_valid,
           bus.o_busy} !== 6'b100000 || bus.o_wr_addr !== 8'd0 || bus.o_tap_idx !== 5'd0) begin
         miscompares++;
         $display("FAIL mid_reset: got flags %b wr_addr %0d tap %0d, required 100000 0 0",
                  {bus.o_sample_ready, bus.o_wr_en, bus.o_acc_en, bus.o_reduce_start,
                   bus.o_dout_valid, bus.o_busy}, bus.o_wr_addr, bus.o_tap_idx);
      end
      repeat (45) tick();
      do_sample(8'd0, 37, 99, 0);
      vectors++;
      if (q_wr.size() + q_acc.size() + q_rs.size() + q_dv.size() != 0) begin
         miscompares++;
         $display("FAIL mid_reset_drain: %0d events outstanding, required 0",
                  q_wr.size() + q_acc.size() + q_rs.size() + q_dv.size());
      end
   endtask

   task automatic test_done_ignored();
      int  base;
      ev_t e;
      base = cyc;
      bus.i_sample_valid = 1'b1;
      push_sample(base, 8'd1, 99, 0, ITERS);
      e = '0;
      e.cyc = base + 46;
      q_dv.push_back(e);
      for (int c = 1; c <= 46; c++) begin
         tick();
         bus.i_sample_valid = 1'b0;
         bus.i_reduce_done  = (c == 10 || c == 45);
         if (c == 40) begin
            vectors++;
            if (bus.o_dout_valid !== 1'b0 || bus.o_busy !== 1'b1) begin
               miscompares++;
               $display("FAIL early_done: got valid %0b busy %0b, required 0 1",
                        bus.o_dout_valid, bus.o_busy);
            end
         end
      end
      tick();
      vectors++;
      if (bus.o_sample_ready !== 1'b1 || bus.o_wr_addr !== 8'd2 ||
          q_wr.size() + q_acc.size() + q_rs.size() + q_dv.size() != 0) begin
         miscompares++;
         $display("FAIL done_ignored: got ready %0b wr_addr %0d outstanding %0d, required 1 2 0",
                  bus.o_sample_ready, bus.o_wr_addr,
                  q_wr.size() + q_acc.size() + q_rs.size() + q_dv.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_enable_stall();
      test_mid_reset();
      test_done_ignored();
      repeat (5) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
